ex_sequencer: RTL and testbench
===============================

EX_SEQUENCER -- requirements
Module: ex_sequencer

Interface
REQ-001 Parameter: MD_TIMEOUT, default 100; maximum cycles waited for md_done_i before abort.
REQ-002 clk_i  in  1  single clock; all state updates on posedge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 id_valid_i  in  1  ID stage holds a real instruction.
REQ-005 id_rs1_i, id_rs2_i  in  5 each  ID source registers.
REQ-006 id_uses_rs2_i  in  1  ID instruction reads rs2 (not immediate form).
REQ-007 ex_valid_i  in  1  EX stage holds a real instruction.
REQ-008 ex_mem_read_i  in  1  EX instruction is a load.
REQ-009 ex_rd_i  in  5  EX destination register.
REQ-010 ex_multicycle_i  in  1  EX instruction is mul/div.
REQ-011 branch_taken_i  in  1  EX branch/jump resolved taken.
REQ-012 mem_busy_i  in  1  data memory not ready; freeze pipeline.
REQ-013 md_done_i  in  1  multi-cycle unit result valid (1-cycle pulse).
REQ-014 pc_write_o, if_id_write_o  out  1 each  PC / IF-ID register enables.
REQ-015 id_ex_bubble_o  out  1  load a NOP into ID-EX.
REQ-016 if_id_flush_o  out  1  clear IF-ID.
REQ-017 ex_hold_o  out  1  hold EX input registers.
REQ-018 md_start_o  out  1  one-cycle start pulse to mul/div unit.
REQ-019 md_abort_o  out  1  one-cycle abort pulse on timeout.
REQ-020 md_timeout_o  out  1  sticky timeout error flag.
REQ-021 stall_cnt_o  out  32  saturating count of cycles with pc_write_o=0.

Function
REQ-022 FSM states: RUN, MD_WAIT; outputs combinational from state and inputs; default pc_write_o=if_id_write_o=1, all others 0.
REQ-023 Priority in RUN, highest first: mem_busy, branch flush, multicycle start, load-use stall.
REQ-024 mem_busy_i=1 (any state): pc_write_o=0, if_id_write_o=0, ex_hold_o=1, no bubble, flush, or md_start_o; any pending RUN action re-evaluates next cycle.
REQ-025 RUN, ex_valid_i & branch_taken_i: if_id_flush_o=1, id_ex_bubble_o=1, pc_write_o=1; stay RUN.
REQ-026 RUN, ex_valid_i & ex_multicycle_i (no branch): md_start_o=1, pc_write_o=0, if_id_write_o=0, ex_hold_o=1; next MD_WAIT, timeout counter cleared.
REQ-027 Load-use hazard = ex_valid_i & ex_mem_read_i & ex_rd_i!=0 & id_valid_i & (ex_rd_i==id_rs1_i | (id_uses_rs2_i & ex_rd_i==id_rs2_i)).
REQ-028 RUN, hazard: pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1 for exactly that cycle; stay RUN.
REQ-029 MD_WAIT, md_done_i=0: pc_write_o=0, if_id_write_o=0, ex_hold_o=1; counter increments; branch_taken_i ignored.
REQ-030 MD_WAIT, md_done_i=1: release holds that cycle (defaults), next RUN.
REQ-031 MD_WAIT, counter reaches MD_TIMEOUT-1 without md_done_i: md_abort_o=1, md_timeout_o set, holds released, next RUN.
REQ-032 md_done_i and timeout in same cycle: done wins, no abort, md_timeout_o unchanged.
REQ-033 md_done_i in RUN ignored; md_start_o never asserted in MD_WAIT.
REQ-034 stall_cnt_o increments when pc_write_o=0, saturates at 0xFFFF_FFFF.

Reset
REQ-035 rst_i=1: next state RUN, counters 0, md_timeout_o=0, stall_cnt_o=0.
REQ-036 While rst_i=1: pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1, all other outputs 0.
REQ-037 Reset in MD_WAIT aborts silently: no md_abort_o pulse.

Structure
REQ-038 Package ex_ctrl_pkg holds state enum typedef, MD_TIMEOUT default, counter widths.
REQ-039 Sub-module hazard_detect holds combinational load-use compare (REQ-027).

Verification
REQ-040 Load x5, next ID add x6,x5,x7: one cycle pc_write_o=0, id_ex_bubble_o=1, then normal; stall_cnt_o=1.
REQ-041 Load to x0 with ID using x0, or rs2 match with id_uses_rs2_i=0: no stall.
REQ-042 Mul in EX, md_done_i after 10 cycles: md_start_o one pulse, holds for 10 cycles, released on done cycle.
REQ-043 Mul, no md_done_i: md_abort_o at cycle 100 of MD_WAIT, md_timeout_o stays 1 until rst_i.
REQ-044 Branch taken + load-use same cycle: flush and bubble, pc_write_o=1, no stall; with mem_busy_i=1 also: freeze only.
REQ-045 rst_i at MD_WAIT cycle 5: RUN next cycle, no abort, stall_cnt_o=0.

Source files
------------

// File: rtl/ex_ctrl_pkg.sv
// EX sequencer shared types and sizes.
// FSM state encoding and counter widths.
package ex_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } seq_state_e;

  localparam int MD_TIMEOUT_DEF = 100;
  localparam int MD_CNT_W       = 16;
  localparam int STALL_CNT_W    = 32;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between EX load and ID sources.
// Purely combinational.
module hazard_detect (
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs2_i,
  output logic       hazard_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = (ex_rd_i == id_rs1_i);
  assign rs2_hit  = id_uses_rs2_i & (ex_rd_i == id_rs2_i);
  assign hazard_o = ex_valid_i & ex_mem_read_i
                  & (ex_rd_i != 5'd0) & id_valid_i
                  & (rs1_hit | rs2_hit);

endmodule

// File: rtl/ex_sequencer.sv
// Pipeline stall/flush sequencer around the EX stage.
// Handles mem freeze, branch flush, mul/div wait and load-use.
module ex_sequencer
  import ex_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_uses_rs2_i,
  input  logic        ex_valid_i,
  input  logic        ex_mem_read_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_multicycle_i,
  input  logic        branch_taken_i,
  input  logic        mem_busy_i,
  input  logic        md_done_i,
  output logic        pc_write_o,
  output logic        if_id_write_o,
  output logic        id_ex_bubble_o,
  output logic        if_id_flush_o,
  output logic        ex_hold_o,
  output logic        md_start_o,
  output logic        md_abort_o,
  output logic        md_timeout_o,
  output logic [31:0] stall_cnt_o
);

  localparam logic [MD_CNT_W-1:0] MD_LAST = MD_CNT_W'(MD_TIMEOUT - 1);

  seq_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]    md_cnt_q, md_cnt_d;
  logic                   timeout_q, timeout_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   hazard;

  hazard_detect u_hazard (
    .ex_valid_i    (ex_valid_i),
    .ex_mem_read_i (ex_mem_read_i),
    .ex_rd_i       (ex_rd_i),
    .id_valid_i    (id_valid_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_uses_rs2_i (id_uses_rs2_i),
    .hazard_o      (hazard)
  );

  // Control outputs and next-state for the FSM and its counters.
  always_comb begin
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    id_ex_bubble_o = 1'b0;
    if_id_flush_o  = 1'b0;
    ex_hold_o      = 1'b0;
    md_start_o     = 1'b0;
    md_abort_o     = 1'b0;
    state_d        = state_q;
    md_cnt_d       = md_cnt_q;
    timeout_d      = timeout_q;
    if (rst_i) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      id_ex_bubble_o = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (mem_busy_i) begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            ex_hold_o     = 1'b1;
          end else if (ex_valid_i && branch_taken_i) begin
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
          end else if (ex_valid_i && ex_multicycle_i) begin
            md_start_o    = 1'b1;
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            ex_hold_o     = 1'b1;
            state_d       = ST_MD_WAIT;
            md_cnt_d      = '0;
          end else if (hazard) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_bubble_o = 1'b1;
          end
        end
        ST_MD_WAIT: begin
          if (md_done_i) begin
            state_d = ST_RUN;
          end else if (md_cnt_q == MD_LAST) begin
            md_abort_o = 1'b1;
            timeout_d  = 1'b1;
            state_d    = ST_RUN;
          end else begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            ex_hold_o     = 1'b1;
            md_cnt_d      = md_cnt_q + MD_CNT_W'(1);
          end
          if (mem_busy_i) begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            ex_hold_o     = 1'b1;
          end
        end
      endcase
    end
  end

  // Saturating count of cycles with the PC frozen.
  always_comb begin
    stall_d = stall_q;
    if (!pc_write_o && (stall_q != '1)) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      md_cnt_q  <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      md_cnt_q  <= md_cnt_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
    end
  end

  assign md_timeout_o = timeout_q & ~rst_i;
  assign stall_cnt_o  = rst_i ? '0 : stall_q;

endmodule

// File: tb/tb_ex_sequencer.sv
// Directed bench for ex_sequencer.
// Vector table for RUN decisions plus mul/div and reset sequences.
module tb_ex_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_uses_rs2;
  logic        ex_valid, ex_mem_read;
  logic [4:0]  ex_rd;
  logic        ex_multi, branch, mem_busy, md_done;
  logic        pc_we, ifid_we, bubble, flush, hold, start;
  logic        abort, tmo;
  logic [31:0] stall_cnt;
  logic [5:0]  outv;

  int total = 0;
  int passed = 0;
  int exp_stall;
  int abort_cyc;

  always #5 clk = ~clk;

  ex_sequencer #(.MD_TIMEOUT(100)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .id_valid_i      (id_valid),
    .id_rs1_i        (id_rs1),
    .id_rs2_i        (id_rs2),
    .id_uses_rs2_i   (id_uses_rs2),
    .ex_valid_i      (ex_valid),
    .ex_mem_read_i   (ex_mem_read),
    .ex_rd_i         (ex_rd),
    .ex_multicycle_i (ex_multi),
    .branch_taken_i  (branch),
    .mem_busy_i      (mem_busy),
    .md_done_i       (md_done),
    .pc_write_o      (pc_we),
    .if_id_write_o   (ifid_we),
    .id_ex_bubble_o  (bubble),
    .if_id_flush_o   (flush),
    .ex_hold_o       (hold),
    .md_start_o      (start),
    .md_abort_o      (abort),
    .md_timeout_o    (tmo),
    .stall_cnt_o     (stall_cnt)
  );

  // {pc_write, if_id_write, bubble, flush, hold, start}
  assign outv = {pc_we, ifid_we, bubble, flush, hold, start};

  typedef struct {
    string      name;
    logic       idv;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u2;
    logic       exv;
    logic       mr;
    logic [4:0] rd;
    logic       br;
    logic       mb;
    logic       dn;
    logic [5:0] exp;
  } vec_t;

  vec_t tv[12];

  function automatic vec_t mk(string n, logic idv, logic [4:0] rs1,
                              logic [4:0] rs2, logic u2, logic exv,
                              logic mr, logic [4:0] rd, logic br,
                              logic mb, logic dn, logic [5:0] e);
    vec_t v;
    v.name = n; v.idv = idv; v.rs1 = rs1; v.rs2 = rs2; v.u2 = u2;
    v.exv = exv; v.mr = mr; v.rd = rd; v.br = br; v.mb = mb;
    v.dn = dn; v.exp = e;
    return v;
  endfunction

  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  task automatic clear_in();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0;
    ex_valid = 0; ex_mem_read = 0; ex_rd = 0; ex_multi = 0;
    branch = 0; mem_busy = 0; md_done = 0;
  endtask

  task automatic apply(vec_t v);
    clear_in();
    id_valid = v.idv; id_rs1 = v.rs1; id_rs2 = v.rs2;
    id_uses_rs2 = v.u2; ex_valid = v.exv; ex_mem_read = v.mr;
    ex_rd = v.rd; branch = v.br; mem_busy = v.mb; md_done = v.dn;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_in();
    rst = 1;
    #1;
    check("rst_outs", {26'd0, outv}, {26'd0, 6'b001000});
    check("rst_misc", {30'd0, abort, tmo}, 32'd0);
    check("rst_stall", stall_cnt, 32'd0);
    @(negedge clk);
    rst = 0;
    #1;
    check("post_rst_stall", stall_cnt, 32'd0);
    check("post_rst_tmo", {31'd0, tmo}, 32'd0);
  endtask

  // Start a mul/div, then wait; done_at/rst_at of 0 means never.
  task automatic run_md(input int done_at, input int rst_at,
                        output int abort_at);
    abort_at = 0;
    @(negedge clk);
    clear_in();
    ex_valid = 1; ex_multi = 1;
    #1;
    check("md_start", {26'd0, outv}, {26'd0, 6'b000011});
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      md_done = (k == done_at);
      rst = (k == rst_at);
      branch = 1;
      #1;
      if (abort) abort_at = k;
      if (k == rst_at) begin
        check("md_rst_outs", {26'd0, outv}, {26'd0, 6'b001000});
        check("md_rst_abort", {31'd0, abort}, 32'd0);
        break;
      end
      if (k == done_at) begin
        check("md_release", {26'd0, outv}, {26'd0, 6'b110000});
        check("md_done_abort", {31'd0, abort}, 32'd0);
        break;
      end
      if (k == 100) begin
        check("md_abort", {31'd0, abort}, 32'd1);
        check("md_abort_outs", {26'd0, outv}, {26'd0, 6'b110000});
        break;
      end
      check("md_hold", {26'd0, outv}, {26'd0, 6'b000010});
    end
    @(negedge clk);
    clear_in();
    rst = 0;
    #1;
  endtask

  initial begin
    rst = 1;
    clear_in();
    tv[0]  = mk("idle",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b110000);
    tv[1]  = mk("lu_rs1",     1, 5, 7, 1, 1, 1, 5, 0, 0, 0, 6'b001000);
    tv[2]  = mk("lu_rs2",     1, 3, 5, 1, 1, 1, 5, 0, 0, 0, 6'b001000);
    tv[3]  = mk("rs2_imm",    1, 3, 5, 0, 1, 1, 5, 0, 0, 0, 6'b110000);
    tv[4]  = mk("ld_x0",      1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 6'b110000);
    tv[5]  = mk("id_invalid", 0, 5, 5, 1, 1, 1, 5, 0, 0, 0, 6'b110000);
    tv[6]  = mk("ex_invalid", 1, 5, 5, 1, 0, 1, 5, 0, 0, 0, 6'b110000);
    tv[7]  = mk("branch",     1, 1, 2, 1, 1, 0, 9, 1, 0, 0, 6'b111100);
    tv[8]  = mk("br_lu",      1, 5, 2, 1, 1, 1, 5, 1, 0, 0, 6'b111100);
    tv[9]  = mk("busy_br_lu", 1, 5, 2, 1, 1, 1, 5, 1, 1, 0, 6'b000010);
    tv[10] = mk("busy",       0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b000010);
    tv[11] = mk("no_load",    1, 5, 5, 1, 1, 0, 5, 0, 0, 1, 6'b110000);

    do_reset();

    @(negedge clk);
    apply(tv[1]);
    id_rs1 = 5; id_rs2 = 7;
    #1;
    check("lu_stall", {26'd0, outv}, {26'd0, 6'b001000});
    @(negedge clk);
    clear_in();
    id_valid = 1; id_rs1 = 5; id_rs2 = 7; id_uses_rs2 = 1;
    #1;
    check("lu_resume", {26'd0, outv}, {26'd0, 6'b110000});
    check("lu_stall_cnt", stall_cnt, 32'd1);

    exp_stall = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      apply(tv[i]);
      #1;
      check(tv[i].name, {26'd0, outv}, {26'd0, tv[i].exp});
      check({tv[i].name, "_abort"}, {31'd0, abort}, 32'd0);
      if (tv[i].exp[5] == 1'b0) exp_stall++;
    end
    @(negedge clk);
    clear_in();
    #1;
    check("tbl_stall_cnt", stall_cnt, exp_stall);

    do_reset();
    run_md(10, 0, abort_cyc);
    check("md10_outs", {26'd0, outv}, {26'd0, 6'b110000});
    check("md10_stall", stall_cnt, 32'd10);
    check("md10_no_abort", abort_cyc, 0);

    do_reset();
    run_md(0, 0, abort_cyc);
    check("to_abort_cyc", abort_cyc, 100);
    check("to_flag", {31'd0, tmo}, 32'd1);
    check("to_stall", stall_cnt, 32'd100);
    repeat (3) @(negedge clk);
    #1;
    check("to_sticky", {31'd0, tmo}, 32'd1);

    do_reset();
    run_md(100, 0, abort_cyc);
    check("done_wins_cyc", abort_cyc, 0);
    check("done_wins_tmo", {31'd0, tmo}, 32'd0);
    check("done_wins_stall", stall_cnt, 32'd100);

    do_reset();
    run_md(0, 5, abort_cyc);
    check("rst_md_abort", abort_cyc, 0);
    check("rst_md_stall", stall_cnt, 32'd0);
    check("rst_md_tmo", {31'd0, tmo}, 32'd0);
    apply(tv[1]);
    #1;
    check("rst_md_run", {26'd0, outv}, {26'd0, 6'b001000});

    @(negedge clk);
    clear_in();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
